// File: rtl/serial_frame_deserializer.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// Each completed frame produces a one-cycle Valid pulse with held data and error flags.
module serial_frame_deserializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             D,
  input  logic             Bit_en,
  output logic [WIDTH-1:0] Data_out,
  output logic             Valid,
  output logic             Parity_err,
  output logic             Frame_err,
  output logic             Busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    if (Bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (!D) begin
            state_d = StData;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        StData: begin
          // Counter doubles as the bit position, so the word fills LSB first.
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (cnt_q == CntW'(i)) shift_d[i] = D;
          end
          if (cnt_q == CntW'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = PARITY_EN ? StParity : StStop;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StParity: begin
          par_d   = D;
          state_d = StStop;
        end
        StStop: begin
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = PARITY_EN ? ((^shift_q) ^ par_q ^ PARITY_ODD) : 1'b0;
          ferr_d  = ~D;
          // A low stop bit means the line is stuck low; don't read it as a new start.
          state_d = D ? StIdle : StWaitIdle;
        end
        StWaitIdle: begin
          if (D) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign Data_out   = data_q;
  assign Valid      = valid_q;
  assign Parity_err = perr_q;
  assign Frame_err  = ferr_q;
  assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Scoreboard bench for serial_frame_deserializer (WIDTH=8, even parity).
// Stimulus pushes expected frames; a negedge monitor pops and compares on each Valid.
module tb_serial_frame_deserializer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       D = 1'b1;
  logic       Bit_en = 1'b0;
  logic [7:0] Data_out;
  logic       Valid;
  logic       Parity_err;
  logic       Frame_err;
  logic       Busy;

  serial_frame_deserializer #(
    .WIDTH     (8),
    .PARITY_EN (1'b1),
    .PARITY_ODD(1'b0)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .D         (D),
    .Bit_en    (Bit_en),
    .Data_out  (Data_out),
    .Valid     (Valid),
    .Parity_err(Parity_err),
    .Frame_err (Frame_err),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   valid_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Valid cycle must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Valid === 1'b1) begin
      exp_t e;
      valid_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got Valid=1 data %0h expected no frame (t=%0t)",
                 Data_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", 32'(Data_out), 32'(e.data));
        check("frame_parity_err", 32'(Parity_err), 32'(e.perr));
        check("frame_frame_err", 32'(Frame_err), 32'(e.ferr));
      end
    end
  end

  // Drives one sampled bit; during disabled cycles D carries the inverse to prove gating.
  task automatic send_bit(input logic b, input int stride);
    for (int i = 0; i < stride - 1; i++) begin
      D      = ~b;
      Bit_en = 1'b0;
      @(negedge Clk);
    end
    D      = b;
    Bit_en = 1'b1;
    @(negedge Clk);
    Bit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int stride, input logic exp_perr, input logic exp_ferr);
    exp_t e;
    e.data = data;
    e.perr = exp_perr;
    e.ferr = exp_ferr;
    exp_q.push_back(e);
    send_bit(1'b0, stride);
    for (int i = 0; i < 8; i++) send_bit(data[i], stride);
    send_bit(par, stride);
    send_bit(stop, stride);
    D = 1'b1;
  endtask

  initial begin
    #1 Rst = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_data", 32'(Data_out), 32'h0);
    check("reset_valid", 32'(Valid), 32'h0);
    check("reset_flags", 32'({Parity_err, Frame_err}), 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);
    Rst = 1'b1;
    @(negedge Clk);

    // Clean frame 0xA5, correct parity.
    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    check("t1_valid_after_stop", 32'(Valid), 32'h1);
    @(negedge Clk);
    check("t1_valid_one_cycle", 32'(Valid), 32'h0);
    check("t1_busy_low", 32'(Busy), 32'h0);
    check("t1_data_held", 32'(Data_out), 32'hA5);

    // Bad parity, then a good frame clears the flag.
    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b1, 1'b0);
    @(negedge Clk);
    check("t2_parity_err_held", 32'(Parity_err), 32'h1);
    send_frame(8'h3C, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    @(negedge Clk);

    // Framing error, long low stretch, then a clean frame.
    send_frame(8'h0F, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1);
    check("t3_busy_wait_idle", 32'(Busy), 32'h1);
    send_bit(1'b1, 1);
    check("t3_idle_after_high", 32'(Busy), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    @(negedge Clk);

    // Sparse strobe: one enabled edge in four.
    send_frame(8'h5A, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    check("t4_valid_after_stop", 32'(Valid), 32'h1);
    @(negedge Clk);
    check("t4_valid_one_cycle", 32'(Valid), 32'h0);

    // Asynchronous reset mid-frame.
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    check("t5_busy_mid_frame", 32'(Busy), 32'h1);
    #2 Rst = 1'b0;
    #1;
    check("t5_async_data", 32'(Data_out), 32'h0);
    check("t5_async_flags", 32'({Valid, Parity_err, Frame_err}), 32'h0);
    check("t5_async_busy", 32'(Busy), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;
    D   = 1'b1;
    @(negedge Clk);
    send_frame(8'h12, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    @(negedge Clk);

    // Back-to-back frames with no idle bit.
    valid_cyc.delete();
    send_frame(8'h01, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    repeat (3) @(negedge Clk);
    check("t6_valid_count", 32'(valid_cyc.size()), 32'd2);
    if (valid_cyc.size() == 2) check("t6_valid_spacing", 32'(valid_cyc[1] - valid_cyc[0]), 32'd11);

    repeat (3) @(negedge Clk);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_deserializer.md
Name: serial_frame_deserializer

Overview:
Receive-side stage that consumes a serial bit stream such as the Q output of the team's d_flipflop capture stage. Each bit is qualified by a sample strobe. The block detects a start bit, shifts in a fixed-width data word LSB first, optionally checks parity, and checks the stop bit. Each completed frame is presented as a parallel word with a one-cycle valid pulse and error flags, for downstream register/FIFO logic.

Parameters:
WIDTH, 8, data bits per frame (legal range 1 to 16).
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0).

Ports:
Clk  input  1  single clock; all state changes on the rising edge.
Rst  input  1  asynchronous, active-low reset; Rst=0 forces reset immediately, independent of Clk.
D  input  1  serial line bit; idle level is 1.
Bit_en  input  1  sample strobe; D is sampled only on rising Clk edges where Bit_en=1.
Data_out  output  WIDTH  last received data word, LSB = first data bit received.
Valid  output  1  one-Clk-cycle pulse marking a completed frame.
Parity_err  output  1  parity mismatch on the last completed frame.
Frame_err  output  1  stop bit was 0 on the last completed frame.
Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE, bit counter=0, shift register=0.
  - Data_out=0, Valid=0, Parity_err=0, Frame_err=0, Busy=0.
  - A partial frame is discarded with no Valid.
  - Reset release is synchronous to Clk; the first sample is taken on the first edge with Rst=1 and Bit_en=1.
- Bit_en=0 on a Clk edge: state, counter and shift register hold. Valid still clears (it never stretches).
- States and transitions (every transition is on a sampled edge, Bit_en=1):
  - IDLE: D=0 -> DATA with counter=0. D=1 -> stay in IDLE.
  - DATA: shift D into the word LSB-first and increment counter. After the WIDTH-th bit: go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: store D as the received parity bit -> STOP.
  - STOP: sample the stop bit (see frame completion below). D=1 -> IDLE. D=0 -> WAIT_IDLE.
  - WAIT_IDLE: stay until D=1 is sampled -> IDLE. A low line after a bad stop bit is never taken as a new start bit.
- Frame completion (the STOP sampling edge):
  - Registered outputs update on that edge: Data_out = assembled word, Valid=1 for exactly one Clk cycle.
  - Parity_err = (XOR of data bits XOR parity bit XOR PARITY_ODD) != 0 when PARITY_EN=1; forced 0 otherwise.
  - Frame_err = ~D.
  - Valid is asserted even when an error flag is set; the flags qualify the word.
- Latency: Valid rises on the same edge that samples the stop bit, so the frame is visible during the following cycle.
- Data_out, Parity_err and Frame_err hold until the next frame completion or reset. They do not change mid-frame.
- Back-to-back frames: a start bit may be sampled on the first Bit_en edge after the STOP edge. No idle bit is required.
- Counter width is clog2(WIDTH+1). The counter never wraps within a frame.
- Busy = (state != IDLE), decoded from registered state.

Test Plan:
- WIDTH=8, even parity, Bit_en=1 every cycle. Send start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> Data_out=8'hA5, Valid high exactly 1 cycle after the stop edge, Parity_err=0, Frame_err=0, Busy low afterwards.
- Same frame with parity bit 1 -> Data_out=8'hA5, Valid=1 for 1 cycle, Parity_err=1, Frame_err=0. Then send 0x3C with correct parity 0 -> Parity_err returns to 0.
- Frame 0x0F (parity 0) with stop bit 0, then D held 0 for 5 samples, then 1, then start of 0x81 (parity 0) -> Frame_err=1 on the first Valid. No Valid during the low stretch. Second Valid gives Data_out=8'h81 with both flags 0.
- Bit_en=1 only every 4th Clk while sending 0x5A (parity 0) -> identical result to the all-enabled case. Valid is a single Clk cycle, not 4.
- Drive Rst=0 asynchronously, between clock edges, after 4 data bits of 0xFF -> all outputs 0 immediately. After release, a full frame 0x12 (parity 0) -> Data_out=8'h12, no stale bits.
- Two frames back-to-back with no idle bit, 0x01 then 0x80 (parity 1 each, even mode) -> two Valid pulses exactly 11 sampled edges apart, with the correct words.
